// File: rtl/sorted_pkt_checker_if.sv
// Avalon-ST sink bundle feeding the sorted packet checker.
// The master drives the beats and the slave returns ready.
interface sorted_pkt_checker_if #(
   parameter int DWIDTH = 8
) ();
   logic [DWIDTH-1:0] data;
   logic              sop;
   logic              eop;
   logic              valid;
   logic              ready;

   modport master (output data, sop, eop, valid, input ready);
   modport slave  (input data, sop, eop, valid, output ready);
endinterface

// File: rtl/sorted_pkt_checker.sv
// Packet sink that checks sorted order, framing and length of each packet.
// It also publishes per-packet status and saturating running counters.
module sorted_pkt_checker #(
   parameter  int DWIDTH      = 8,
   parameter  int MAX_PKT_LEN = 256,
   parameter  int CWIDTH      = 16,
   localparam int LWIDTH      = $clog2(MAX_PKT_LEN) + 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   sorted_pkt_checker_if.slave snk,
   input  logic              stall_i,
   output logic              pkt_done_o,
   output logic              pkt_ok_o,
   output logic [LWIDTH-1:0] pkt_len_o,
   output logic [DWIDTH-1:0] pkt_first_o,
   output logic [DWIDTH-1:0] pkt_last_o,
   output logic              err_order_o,
   output logic              err_len_o,
   output logic              err_frame_o,
   output logic [CWIDTH-1:0] pkt_cnt_o,
   output logic [CWIDTH-1:0] bad_cnt_o,
   output logic [CWIDTH-1:0] drop_cnt_o
);

   localparam logic [LWIDTH-1:0] LMAX = LWIDTH'(MAX_PKT_LEN + 1);

   typedef enum logic [1:0] {IDLE_S, RECV_S, REPORT_S} state_t;

   state_t            r_state;
   logic [DWIDTH-1:0] r_prev, r_first;
   logic [LWIDTH-1:0] r_len;
   logic              r_order, r_len_err, r_frame;

   logic              r_pkt_done, r_pkt_ok, r_err_order, r_err_len, r_err_frame;
   logic [LWIDTH-1:0] r_pkt_len;
   logic [DWIDTH-1:0] r_pkt_first, r_pkt_last;
   logic [CWIDTH-1:0] r_pkt_cnt, r_bad_cnt, r_drop_cnt;

   logic              w_acc, w_order_nxt, w_len_err_nxt, w_frame_nxt, w_ok;
   logic [LWIDTH-1:0] w_len_inc;

   assign snk.ready = !stall_i && (r_state != REPORT_S);
   assign w_acc     = snk.valid && snk.ready;

   // Flags as they stand once the current beat is folded in, so an eop beat
   // that is itself out of order still lands in this packet's report.
   always_comb begin
      w_len_inc     = (r_len == LMAX) ? LMAX : r_len + LWIDTH'(1);
      w_order_nxt   = r_order | (snk.data < r_prev);
      w_len_err_nxt = r_len_err | (w_len_inc == LMAX);
      w_frame_nxt   = r_frame | snk.sop;
      w_ok          = !(w_order_nxt | w_len_err_nxt | w_frame_nxt);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= IDLE_S;
         r_prev      <= '0;
         r_first     <= '0;
         r_len       <= '0;
         r_order     <= 1'b0;
         r_len_err   <= 1'b0;
         r_frame     <= 1'b0;
         r_pkt_done  <= 1'b0;
         r_pkt_ok    <= 1'b0;
         r_pkt_len   <= '0;
         r_pkt_first <= '0;
         r_pkt_last  <= '0;
         r_err_order <= 1'b0;
         r_err_len   <= 1'b0;
         r_err_frame <= 1'b0;
         r_pkt_cnt   <= '0;
         r_bad_cnt   <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_pkt_done <= 1'b0;
         case (r_state)
            IDLE_S: begin
               if (w_acc && snk.sop) begin
                  r_prev    <= snk.data;
                  r_first   <= snk.data;
                  r_len     <= LWIDTH'(1);
                  r_order   <= 1'b0;
                  r_len_err <= 1'b0;
                  r_frame   <= 1'b0;
                  if (snk.eop) begin
                     // Single-beat packet reports clean with first == last.
                     r_state     <= REPORT_S;
                     r_pkt_done  <= 1'b1;
                     r_pkt_ok    <= 1'b1;
                     r_pkt_len   <= LWIDTH'(1);
                     r_pkt_first <= snk.data;
                     r_pkt_last  <= snk.data;
                     r_err_order <= 1'b0;
                     r_err_len   <= 1'b0;
                     r_err_frame <= 1'b0;
                     if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + CWIDTH'(1);
                  end else begin
                     r_state <= RECV_S;
                  end
               end else if (w_acc) begin
                  if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CWIDTH'(1);
               end
            end
            RECV_S: begin
               if (w_acc) begin
                  r_prev    <= snk.data;
                  r_len     <= w_len_inc;
                  r_order   <= w_order_nxt;
                  r_len_err <= w_len_err_nxt;
                  r_frame   <= w_frame_nxt;
                  if (snk.eop) begin
                     r_state     <= REPORT_S;
                     r_pkt_done  <= 1'b1;
                     r_pkt_ok    <= w_ok;
                     r_pkt_len   <= w_len_inc;
                     r_pkt_first <= r_first;
                     r_pkt_last  <= snk.data;
                     r_err_order <= w_order_nxt;
                     r_err_len   <= w_len_err_nxt;
                     r_err_frame <= w_frame_nxt;
                     if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + CWIDTH'(1);
                     if (!w_ok && r_bad_cnt != '1) r_bad_cnt <= r_bad_cnt + CWIDTH'(1);
                  end
               end
            end
            REPORT_S: r_state <= IDLE_S;
            default:  r_state <= IDLE_S;
         endcase
      end
   end

   assign pkt_done_o  = r_pkt_done;
   assign pkt_ok_o    = r_pkt_ok;
   assign pkt_len_o   = r_pkt_len;
   assign pkt_first_o = r_pkt_first;
   assign pkt_last_o  = r_pkt_last;
   assign err_order_o = r_err_order;
   assign err_len_o   = r_err_len;
   assign err_frame_o = r_err_frame;
   assign pkt_cnt_o   = r_pkt_cnt;
   assign bad_cnt_o   = r_bad_cnt;
   assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_sorted_pkt_checker.sv
// Directed bench for sorted_pkt_checker with MAX_PKT_LEN=4 so the length
// limit is reachable with short packets.
module tb_sorted_pkt_checker;
   localparam int DW = 8;
   localparam int ML = 4;
   localparam int CW = 16;
   localparam int LW = $clog2(ML) + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stall = 1'b0;
   logic rand_stall = 1'b0;
   logic          done, ok, e_ord, e_len, e_frm;
   logic [LW-1:0] len;
   logic [DW-1:0] first, last;
   logic [CW-1:0] pcnt, bcnt, dcnt;
   int checks = 0;
   int failures = 0;

   sorted_pkt_checker_if #(.DWIDTH(DW)) bus ();

   sorted_pkt_checker #(.DWIDTH(DW), .MAX_PKT_LEN(ML), .CWIDTH(CW)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .snk(bus), .stall_i(stall),
      .pkt_done_o(done), .pkt_ok_o(ok), .pkt_len_o(len),
      .pkt_first_o(first), .pkt_last_o(last),
      .err_order_o(e_ord), .err_len_o(e_len), .err_frame_o(e_frm),
      .pkt_cnt_o(pcnt), .bad_cnt_o(bcnt), .drop_cnt_o(dcnt)
   );

   always #5 clk = ~clk;

   // Presents one beat and returns after the edge that accepts it (+1).
   // waits = number of negedges seen with ready low before acceptance.
   task automatic beat(input logic [DW-1:0] d, input logic s, input logic e, output int waits);
      waits = 0;
      @(negedge clk);
      bus.data = d; bus.sop = s; bus.eop = e; bus.valid = 1'b1;
      if (rand_stall) stall = 1'($urandom_range(0, 1));
      #1;
      while (!bus.ready && waits < 40) begin
         @(negedge clk);
         waits++;
         if (rand_stall) stall = (waits > 20) ? 1'b0 : 1'($urandom_range(0, 1));
         #1;
      end
      if (!bus.ready) begin
         checks++; failures++;
         $display("FAIL beat_timeout ready=%0b required=1", bus.ready);
      end
      @(posedge clk); #1;
      bus.valid = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0;
      stall = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      checks++; if ({done, ok, len, first, last, e_ord, e_len, e_frm} !== '0) begin failures++; $display("FAIL reset_report got=%0h required=0", {done, ok, len, first, last, e_ord, e_len, e_frm}); end
      checks++; if ({pcnt, bcnt, dcnt} !== '0) begin failures++; $display("FAIL reset_counters got=%0h required=0", {pcnt, bcnt, dcnt}); end
      checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b required=1", bus.ready); end
      stall = 1'b1; #1;
      checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%0b required=0", bus.ready); end
      stall = 1'b0;
   endtask

   task automatic test_sorted();
      int w;
      beat(8'd3, 1, 0, w); beat(8'd5, 0, 0, w); beat(8'd5, 0, 0, w);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL sorted_early_done got=%0b required=0", done); end
      beat(8'd9, 0, 1, w);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL sorted_done got=%0b required=1", done); end
      checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL sorted_report_ready got=%0b required=0", bus.ready); end
      checks++; if ({ok, e_ord, e_len, e_frm} !== 4'b1000) begin failures++; $display("FAIL sorted_flags got=%b required=1000", {ok, e_ord, e_len, e_frm}); end
      checks++; if (len !== 3'd4 || first !== 8'd3 || last !== 8'd9) begin failures++; $display("FAIL sorted_fields len=%0d first=%0d last=%0d required 4/3/9", len, first, last); end
      checks++; if (pcnt !== 16'd1 || bcnt !== 16'd0) begin failures++; $display("FAIL sorted_cnt pkt=%0d bad=%0d required 1/0", pcnt, bcnt); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL sorted_done_pulse got=%0b required=0", done); end
      checks++; if (len !== 3'd4 || last !== 8'd9 || ok !== 1'b1) begin failures++; $display("FAIL sorted_hold len=%0d last=%0d ok=%0b required 4/9/1", len, last, ok); end
   endtask

   task automatic test_order();
      int w;
      beat(8'd7, 1, 0, w); beat(8'd2, 0, 0, w); beat(8'd8, 0, 1, w);
      checks++; if ({done, ok, e_ord, e_len, e_frm} !== 5'b10100) begin failures++; $display("FAIL order_flags got=%b required=10100", {done, ok, e_ord, e_len, e_frm}); end
      checks++; if (len !== 3'd3 || first !== 8'd7 || last !== 8'd8) begin failures++; $display("FAIL order_fields len=%0d first=%0d last=%0d required 3/7/8", len, first, last); end
      checks++; if (pcnt !== 16'd2 || bcnt !== 16'd1) begin failures++; $display("FAIL order_cnt pkt=%0d bad=%0d required 2/1", pcnt, bcnt); end
   endtask

   task automatic test_back_to_back();
      int w;
      beat(8'hAA, 1, 1, w);
      checks++; if ({done, ok, e_ord, e_len, e_frm} !== 5'b11000) begin failures++; $display("FAIL single_flags got=%b required=11000", {done, ok, e_ord, e_len, e_frm}); end
      checks++; if (len !== 3'd1 || first !== 8'hAA || last !== 8'hAA) begin failures++; $display("FAIL single_fields len=%0d first=%0h last=%0h required 1/aa/aa", len, first, last); end
      beat(8'h10, 1, 0, w);
      checks++; if (w !== 1) begin failures++; $display("FAIL b2b_gap waits=%0d required=1", w); end
      beat(8'h20, 0, 1, w);
      checks++; if (ok !== 1'b1 || len !== 3'd2 || first !== 8'h10 || pcnt !== 16'd4) begin failures++; $display("FAIL b2b_second ok=%0b len=%0d first=%0h pkt=%0d required 1/2/10/4", ok, len, first, pcnt); end
   endtask

   task automatic test_len();
      int w;
      beat(8'd1, 1, 0, w);
      for (int i = 2; i <= 5; i++) beat(8'(i), 0, 0, w);
      beat(8'd6, 0, 1, w);
      checks++; if ({done, ok, e_ord, e_len, e_frm} !== 5'b10010) begin failures++; $display("FAIL len_flags got=%b required=10010", {done, ok, e_ord, e_len, e_frm}); end
      checks++; if (len !== 3'd5 || last !== 8'd6) begin failures++; $display("FAIL len_sat len=%0d last=%0d required 5/6", len, last); end
      checks++; if (pcnt !== 16'd5 || bcnt !== 16'd2) begin failures++; $display("FAIL len_cnt pkt=%0d bad=%0d required 5/2", pcnt, bcnt); end
   endtask

   task automatic test_orphan_frame();
      int w;
      beat(8'h33, 0, 0, w); beat(8'h11, 0, 1, w);
      checks++; if (dcnt !== 16'd2 || done !== 1'b0) begin failures++; $display("FAIL orphan_drop drop=%0d done=%0b required 2/0", dcnt, done); end
      beat(8'd1, 1, 0, w); beat(8'd2, 0, 1, w);
      checks++; if (done !== 1'b1 || ok !== 1'b1 || len !== 3'd2 || pcnt !== 16'd6) begin failures++; $display("FAIL orphan_pkt done=%0b ok=%0b len=%0d pkt=%0d required 1/1/2/6", done, ok, len, pcnt); end
      beat(8'd1, 1, 0, w); beat(8'd2, 1, 0, w); beat(8'd3, 0, 1, w);
      checks++; if ({done, ok, e_ord, e_len, e_frm} !== 5'b10001) begin failures++; $display("FAIL frame_flags got=%b required=10001", {done, ok, e_ord, e_len, e_frm}); end
      checks++; if (len !== 3'd3 || bcnt !== 16'd3 || dcnt !== 16'd2) begin failures++; $display("FAIL frame_fields len=%0d bad=%0d drop=%0d required 3/3/2", len, bcnt, dcnt); end
   endtask

   task automatic test_stall_reset();
      int w;
      rand_stall = 1'b1;
      beat(8'd1, 1, 0, w); beat(8'd2, 0, 0, w); beat(8'd3, 0, 0, w); beat(8'd4, 0, 1, w);
      rand_stall = 1'b0;
      checks++; if ({done, ok, e_ord, e_len, e_frm} !== 5'b11000) begin failures++; $display("FAIL stall_flags got=%b required=11000", {done, ok, e_ord, e_len, e_frm}); end
      checks++; if (len !== 3'd4 || first !== 8'd1 || last !== 8'd4 || pcnt !== 16'd8) begin failures++; $display("FAIL stall_fields len=%0d first=%0d last=%0d pkt=%0d required 4/1/4/8", len, first, last, pcnt); end
      beat(8'd5, 1, 0, w); beat(8'd6, 0, 0, w);
      @(negedge clk); rst_n = 1'b0; #1;
      checks++; if ({done, ok, len, first, last, e_ord, e_len, e_frm, pcnt, bcnt, dcnt} !== '0) begin failures++; $display("FAIL midrst_outputs done=%0b ok=%0b len=%0d pkt=%0d bad=%0d drop=%0d required all 0", done, ok, len, pcnt, bcnt, dcnt); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_nodone got=%0b required=0", done); end
      beat(8'd4, 1, 0, w); beat(8'd4, 0, 1, w);
      checks++; if (done !== 1'b1 || ok !== 1'b1 || len !== 3'd2 || pcnt !== 16'd1 || bcnt !== 16'd0) begin failures++; $display("FAIL post_rst done=%0b ok=%0b len=%0d pkt=%0d bad=%0d required 1/1/2/1/0", done, ok, len, pcnt, bcnt); end
   endtask

   initial begin
      bus.data = '0; bus.sop = 1'b0; bus.eop = 1'b0; bus.valid = 1'b0;
      repeat (3) @(posedge clk);
      test_reset();
      @(negedge clk); rst_n = 1'b1;
      test_sorted();
      test_order();
      test_back_to_back();
      test_len();
      test_orphan_frame();
      test_stall_reset();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
